// File: rtl/reg_writeback.sv
// reg_writeback: write-side master for the CPU register file.
// Results from execute are buffered in a small in-order FIFO and drained one
// entry per cycle onto the registered register-file write port. A decode-stage
// query reports whether a register still has a write in flight.
// Optional feature macro: WB_FORWARD_EN adds fwd_data, the youngest pending
// value for the queried register, so decode can forward instead of stalling.
module reg_writeback #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              res_valid,
  output logic              res_ready,
  input  logic [ADDR_W-1:0] res_addr,
  input  logic [DATA_W-1:0] res_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [ADDR_W-1:0] q_addr,
  output logic              pend_hit
`ifdef WB_FORWARD_EN
  ,output logic [DATA_W-1:0] fwd_data
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] r_memAddr [DEPTH];
  logic [DATA_W-1:0] r_memData [DEPTH];
  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [CNT_W-1:0]  r_count;

  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic              w_pendHit;
  logic [PTR_W-1:0]  w_idx;

  // Ready depends only on the registered count, so a full FIFO never takes a
  // result even if an entry drains in the same cycle. Writes to r0 complete
  // the handshake but are dropped because r0 is hardwired to zero.
  assign res_ready = !rst && (r_count != CNT_W'(DEPTH));
  assign w_accept  = res_valid && res_ready;
  assign w_push    = w_accept && (res_addr != '0);
  assign w_pop     = (r_count != '0);

  // FIFO storage needs no reset; occupancy is tracked by the count alone.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_memAddr[r_wrPtr] <= res_addr;
      r_memData[r_wrPtr] <= res_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Registered write port: the head entry moves out one cycle after it was
  // accepted, and address/data hold their last value when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= w_pop;
      if (w_pop) begin
        rf_waddr <= r_memAddr[r_rdPtr];
        rf_wdata <= r_memData[r_rdPtr];
      end
    end
  end

  // Pending-write detection over the valid FIFO entries and the output stage.
  always_comb begin
    w_pendHit = 1'b0;
    w_idx     = '0;
    if (rf_we && (rf_waddr == q_addr)) begin
      w_pendHit = 1'b1;
    end
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_rdPtr + PTR_W'(i);
      if ((CNT_W'(i) < r_count) && (r_memAddr[w_idx] == q_addr)) begin
        w_pendHit = 1'b1;
      end
    end
    if (q_addr == '0) begin
      w_pendHit = 1'b0;
    end
  end

  assign pend_hit = w_pendHit;

`ifdef WB_FORWARD_EN
  logic [DATA_W-1:0] w_fwdData;
  logic [PTR_W-1:0]  w_fwdIdx;

  // Youngest match wins: start from the output stage, then let each newer
  // FIFO entry (oldest to newest) override it.
  always_comb begin
    w_fwdData = '0;
    w_fwdIdx  = '0;
    if (rf_we && (rf_waddr == q_addr)) begin
      w_fwdData = rf_wdata;
    end
    for (int i = 0; i < DEPTH; i++) begin
      w_fwdIdx = r_rdPtr + PTR_W'(i);
      if ((CNT_W'(i) < r_count) && (r_memAddr[w_fwdIdx] == q_addr)) begin
        w_fwdData = r_memData[w_fwdIdx];
      end
    end
    if (q_addr == '0) begin
      w_fwdData = '0;
    end
  end

  assign fwd_data = w_fwdData;
`endif

endmodule
